// File: rtl/bootrom_ahb_if.sv
// -----------------------------------------------------------------------------
// bootrom_ahb_if
//
// AHB-Lite slave front end for a synchronous, read-only boot ROM.
//
// Reads complete with zero wait states. The ROM is enabled combinationally in
// the address phase, and its registered output is returned in the data phase.
// A write gets the two-cycle AHB ERROR response: one cycle of
// HREADYOUT=0/HRESP=1, then one cycle of HREADYOUT=1/HRESP=1.
//
// Parameters
//   AW_ADDR_W  ROM word-address width. The ROM holds 2**AW_ADDR_W words.
//
// Ports
//   HCLK       in   1           clock; all state changes on the rising edge
//   HRESETn    in   1           asynchronous active-low reset
//   HSEL       in   1           slave select
//   HADDR      in   32          byte address
//   HTRANS     in   2           transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     in   1           write flag
//   HSIZE      in   3           transfer size (ignored; always full word)
//   HREADY     in   1           bus-level ready
//   HREADYOUT  out  1           slave ready
//   HRESP      out  1           0 = OKAY, 1 = ERROR
//   HRDATA     out  32          read data
//   EN         out  1           ROM enable, active-high
//   W_ADDR     out  AW_ADDR_W   ROM word address
//   RDATA      in   32          ROM data, valid the cycle after EN
// -----------------------------------------------------------------------------
module bootrom_ahb_if #(
   parameter int unsigned AW_ADDR_W = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [31:0]          HRDATA,
   output logic                 EN,
   output logic [AW_ADDR_W-1:0] W_ADDR,
   input  logic [31:0]          RDATA
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StErr1 = 2'd2,
      StErr2 = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   accept;

   // Sub-word lanes and the bits above the ROM are dropped on purpose: the
   // master picks its byte lanes, and addresses past the ROM wrap around.
   logic unused_bits;
   assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:AW_ADDR_W+2], HADDR[1:0]};

   // HTRANS[1] covers both NONSEQ and SEQ. The ERR1 term keeps a transfer out
   // during the first error cycle, even if the bus does not hold HREADY low.
   assign accept = HSEL & HREADY & HTRANS[1] & (state_q != StErr1);

   assign EN     = accept & ~HWRITE;
   assign W_ADDR = HADDR[AW_ADDR_W+1:2];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = StIdle;
      if (state_q == StErr1) begin
         state_d = StErr2;
      end else if (accept) begin
         state_d = HWRITE ? StErr1 : StRd;
      end
   end

   // The outputs decode the state alone, so reset forces them at once.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = 32'h0;
      unique case (state_q)
         StIdle: ;
         StRd:   HRDATA = RDATA;
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         StErr2: HRESP = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bootrom_ahb_if.sv
module tb_bootrom_ahb_if;

   localparam int unsigned AW = 8;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic          EN;
   logic [AW-1:0] W_ADDR;
   logic [31:0]   RDATA;

   logic [31:0]   rom [0:255];

   int nvec = 0;
   int nerr = 0;

   always #5 HCLK = ~HCLK;

   bootrom_ahb_if #(.AW_ADDR_W(AW)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .EN        (EN),
      .W_ADDR    (W_ADDR),
      .RDATA     (RDATA)
   );

   // Synchronous ROM: data registered one cycle after EN.
   always @(posedge HCLK) begin
      if (EN) RDATA <= rom[W_ADDR];
   end

   task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic write, input logic [2:0] size, input logic ready);
      HSEL   = sel;
      HTRANS = trans;
      HADDR  = addr;
      HWRITE = write;
      HSIZE  = size;
      HREADY = ready;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 1'b1);
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      idle();
      #3;
      chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      chk("rst_hresp", {31'b0, HRESP}, 32'h0);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_en_idle", {31'b0, EN}, 32'h0);
      drive(1'b1, 2'b10, 32'h0000_000C, 1'b0, 3'd2, 1'b1);
      #1;
      chk("rst_en_follows", {31'b0, EN}, 32'h1);
      chk("rst_waddr_follows", {24'b0, W_ADDR}, 32'h3);
      idle();
      step();
      step();
      HRESETn = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      drive(1'b1, 2'b10, 32'h0000_0010, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("sr_en", {31'b0, EN}, 32'h1);
      chk("sr_waddr", {24'b0, W_ADDR}, 32'h4);
      step();
      idle();
      @(negedge HCLK);
      chk("sr_hrdata", HRDATA, 32'hDEAD_BEEF);
      chk("sr_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      chk("sr_hresp", {31'b0, HRESP}, 32'h0);
      step();
      @(negedge HCLK);
      chk("sr_idle_hrdata", HRDATA, 32'h0);
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [0:3];
      exp[0] = 32'h1111_0000;
      exp[1] = 32'h2222_0001;
      exp[2] = 32'h3333_0002;
      exp[3] = 32'h4444_0003;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b10, 32'(4 * i), 1'b0, 3'd2, 1'b1);
         @(negedge HCLK);
         chk("b2b_en", {31'b0, EN}, 32'h1);
         chk("b2b_waddr", {24'b0, W_ADDR}, 32'(i));
         chk("b2b_hreadyout", {31'b0, HREADYOUT}, 32'h1);
         if (i > 0) chk("b2b_hrdata", HRDATA, exp[i-1]);
         step();
      end
      idle();
      @(negedge HCLK);
      chk("b2b_hrdata_last", HRDATA, exp[3]);
      chk("b2b_hreadyout_last", {31'b0, HREADYOUT}, 32'h1);
      step();
   endtask

   task automatic test_write_error();
      drive(1'b1, 2'b10, 32'h0000_0020, 1'b1, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("wr_en", {31'b0, EN}, 32'h0);
      chk("wr_addr_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      step();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 1'b0);
      @(negedge HCLK);
      chk("wr_err1_hreadyout", {31'b0, HREADYOUT}, 32'h0);
      chk("wr_err1_hresp", {31'b0, HRESP}, 32'h1);
      step();
      idle();
      @(negedge HCLK);
      chk("wr_err2_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      chk("wr_err2_hresp", {31'b0, HRESP}, 32'h1);
      step();
      @(negedge HCLK);
      chk("wr_idle_hresp", {31'b0, HRESP}, 32'h0);
      chk("wr_idle_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      step();
   endtask

   task automatic test_write_then_read();
      drive(1'b1, 2'b10, 32'h0000_0020, 1'b1, 3'd2, 1'b1);
      step();
      // Read held through ERR1; HREADY left high so only the state blocks it.
      drive(1'b1, 2'b10, 32'h0000_0008, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("wtr_err1_en", {31'b0, EN}, 32'h0);
      chk("wtr_err1_hreadyout", {31'b0, HREADYOUT}, 32'h0);
      step();
      @(negedge HCLK);
      chk("wtr_err2_hresp", {31'b0, HRESP}, 32'h1);
      chk("wtr_err2_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      chk("wtr_err2_en", {31'b0, EN}, 32'h1);
      chk("wtr_err2_waddr", {24'b0, W_ADDR}, 32'h2);
      step();
      idle();
      @(negedge HCLK);
      chk("wtr_rd_hrdata", HRDATA, 32'h3333_0002);
      chk("wtr_rd_hresp", {31'b0, HRESP}, 32'h0);
      chk("wtr_rd_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      step();
   endtask

   task automatic test_alias_and_byte();
      drive(1'b1, 2'b10, 32'h0000_0404, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("alias_waddr", {24'b0, W_ADDR}, 32'h1);
      step();
      // Byte read as a SEQ transfer.
      drive(1'b1, 2'b11, 32'h0000_0007, 1'b0, 3'd0, 1'b1);
      @(negedge HCLK);
      chk("alias_hrdata", HRDATA, 32'h2222_0001);
      chk("byte_en", {31'b0, EN}, 32'h1);
      chk("byte_waddr", {24'b0, W_ADDR}, 32'h1);
      step();
      idle();
      @(negedge HCLK);
      chk("byte_hrdata", HRDATA, 32'h2222_0001);
      step();
   endtask

   task automatic test_enable_gating();
      drive(1'b1, 2'b00, 32'h0000_0010, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("gate_idle_en", {31'b0, EN}, 32'h0);
      step();
      drive(1'b1, 2'b01, 32'h0000_0010, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("gate_busy_en", {31'b0, EN}, 32'h0);
      step();
      drive(1'b0, 2'b10, 32'h0000_0010, 1'b0, 3'd2, 1'b1);
      @(negedge HCLK);
      chk("gate_nosel_en", {31'b0, EN}, 32'h0);
      step();
      idle();
      @(negedge HCLK);
      chk("gate_no_data", HRDATA, 32'h0);
      chk("gate_no_err", {31'b0, HRESP}, 32'h0);
      step();
   endtask

   task automatic test_hready_low_in_rd();
      drive(1'b1, 2'b10, 32'h0000_0000, 1'b0, 3'd2, 1'b1);
      step();
      drive(1'b1, 2'b10, 32'h0000_0004, 1'b0, 3'd2, 1'b0);
      @(negedge HCLK);
      chk("stall_hrdata", HRDATA, 32'h1111_0000);
      chk("stall_en", {31'b0, EN}, 32'h0);
      step();
      idle();
      @(negedge HCLK);
      chk("stall_idle_hrdata", HRDATA, 32'h0);
      step();
   endtask

   task automatic test_reset_mid_transfer();
      // Reset during ERR1.
      drive(1'b1, 2'b10, 32'h0000_0020, 1'b1, 3'd2, 1'b1);
      step();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 1'b0);
      @(negedge HCLK);
      chk("rerr_pre_hreadyout", {31'b0, HREADYOUT}, 32'h0);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("rerr_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      chk("rerr_hresp", {31'b0, HRESP}, 32'h0);
      step();
      idle();
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("rerr_post_hresp", {31'b0, HRESP}, 32'h0);
      step();
      @(negedge HCLK);
      chk("rerr_post2_hresp", {31'b0, HRESP}, 32'h0);
      chk("rerr_post2_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      step();
      // Reset during RD.
      drive(1'b1, 2'b10, 32'h0000_0010, 1'b0, 3'd2, 1'b1);
      step();
      idle();
      @(negedge HCLK);
      chk("rrd_pre_hrdata", HRDATA, 32'hDEAD_BEEF);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("rrd_hrdata", HRDATA, 32'h0);
      step();
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("rrd_post_hrdata", HRDATA, 32'h0);
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = {24'hA5A5A5, 8'(i)};
      rom[0] = 32'h1111_0000;
      rom[1] = 32'h2222_0001;
      rom[2] = 32'h3333_0002;
      rom[3] = 32'h4444_0003;
      rom[4] = 32'hDEAD_BEEF;
      RDATA  = 32'h0;

      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_error();
      test_write_then_read();
      test_alias_and_byte();
      test_enable_gating();
      test_hready_low_in_rd();
      test_reset_mid_transfer();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/bootrom_ahb_if.md
BOOTROM_AHB_IF -- requirements
Module: bootrom_ahb_if

Interface
REQ-001 The block SHALL have parameter AW_ADDR_W, default 8, giving the ROM word-address width.
REQ-002 The block SHALL have port HCLK, input, 1, the single clock; all state is rising-edge.
REQ-003 The block SHALL have port HRESETn, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port HSEL, input, 1, the AHB-Lite slave select.
REQ-005 The block SHALL have port HADDR, input, 32, the AHB address.
REQ-006 The block SHALL have port HTRANS, input, 2, the AHB transfer type.
REQ-007 The block SHALL have port HWRITE, input, 1, the AHB write flag.
REQ-008 The block SHALL have port HSIZE, input, 3, the AHB transfer size; it is accepted and ignored.
REQ-009 The block SHALL have port HREADY, input, 1, the bus-level ready.
REQ-010 The block SHALL have port HREADYOUT, output, 1, the slave ready.
REQ-011 The block SHALL have port HRESP, output, 1, the slave response, where 0 is OKAY and 1 is ERROR.
REQ-012 The block SHALL have port HRDATA, output, 32, the read data.
REQ-013 The block SHALL have port EN, output, 1, the ROM enable, active-high.
REQ-014 The block SHALL have port W_ADDR, output, AW_ADDR_W, the ROM word address.
REQ-015 The block SHALL have port RDATA, input, 32, the ROM data, valid the cycle after EN is high.

Function
REQ-016 The block SHALL define an accepted transfer as HSEL & HREADY & HTRANS[1] at a rising edge, when the state is not ERR1.
REQ-017 The block SHALL drive EN combinationally as HSEL & HREADY & HTRANS[1] & !HWRITE & (state != ERR1).
- EN is low for IDLE/BUSY, for writes, and when the slave is not selected.
REQ-018 The block SHALL drive W_ADDR combinationally as HADDR[AW_ADDR_W+1:2].
- HADDR[1:0] and the upper bits are ignored.
- Addresses above the ROM size alias (wrap-around).
REQ-019 The block SHALL use four states: IDLE, RD, ERR1, ERR2.
REQ-020 The state transitions SHALL be, on each rising edge:
- an accepted read goes to RD;
- an accepted write goes to ERR1;
- ERR1 goes to ERR2 unconditionally;
- from IDLE, RD or ERR2, no accepted transfer goes to IDLE.
REQ-021 In IDLE and RD the block SHALL drive HREADYOUT=1 and HRESP=0, so reads complete with zero wait states.
REQ-022 In RD the block SHALL drive HRDATA=RDATA; in every other state it SHALL drive HRDATA=32'h0.
REQ-023 In ERR1 the block SHALL drive HREADYOUT=0 and HRESP=1.
REQ-024 In ERR2 the block SHALL drive HREADYOUT=1 and HRESP=1, completing the two-cycle AHB ERROR response.
REQ-025 A transfer presented while in ERR1 SHALL NOT be accepted, since HREADY is low then.
REQ-026 A transfer accepted in ERR2 SHALL be processed normally, with no dead cycle.
REQ-027 Back-to-back reads SHALL sustain one word per cycle, with EN held high and W_ADDR updated every cycle.
REQ-028 If HREADY is low while in RD (another slave stalling), the block SHALL neither accept nor re-enable the ROM, and SHALL go to IDLE at the next edge.
REQ-029 Byte and halfword reads SHALL return the full aligned word; the master selects the lanes.
REQ-030 A SEQ transfer SHALL be handled identically to a NONSEQ transfer.

Reset
REQ-031 HRESETn low SHALL immediately force state to IDLE, regardless of the clock.
REQ-032 Reset values SHALL be: HREADYOUT=1, HRESP=0, HRDATA=0; EN and W_ADDR follow the inputs combinationally.
REQ-033 A reset asserted mid-ERR1 or mid-RD SHALL abandon the transfer, with no ERROR or data phase after release.
REQ-034 Release of HRESETn SHALL be synchronised externally; the block adds no reset synchroniser.

Verification
REQ-035 Reset followed by a single word read at 0x0000_0010, with ROM word 4 = 0xDEADBEEF, SHALL give EN=1 and W_ADDR=4 in the address phase, then HRDATA=0xDEADBEEF, HREADYOUT=1 and HRESP=0 in the next cycle.
REQ-036 Four back-to-back NONSEQ reads at 0x0,0x4,0x8,0xC SHALL return four words in four consecutive data phases, with no HREADYOUT low.
REQ-037 A write to 0x0000_0020 SHALL give EN=0, then one cycle of HREADYOUT=0/HRESP=1, then one cycle of HREADYOUT=1/HRESP=1, then IDLE.
REQ-038 A write followed immediately by a read, with the read held through ERR1, SHALL give the read accepted in ERR2 and its data returned in the following cycle.
REQ-039 A read at 0x0000_0404 with AW_ADDR_W=8 SHALL drive W_ADDR=1 (alias), and a byte read at 0x0000_0007 SHALL drive W_ADDR=1 and return the full word.
REQ-040 HRESETn asserted low during ERR1 SHALL force HREADYOUT=1 and HRESP=0 immediately, and SHALL produce no ERR2 after release.
